// File: rtl/wasm_run_pkg.sv
// Shared state encoding and termination codes
// for the WASM run controller.
package wasm_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CORE_RST,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [2:0] ST_NONE        = 3'd0;
  localparam logic [2:0] ST_FINISH      = 3'd1;
  localparam logic [2:0] ST_INSTR_ERROR = 3'd2;
  localparam logic [2:0] ST_STACK_EXC   = 3'd3;
  localparam logic [2:0] ST_EMPTY_POP   = 3'd4;
  localparam logic [2:0] ST_TIMEOUT     = 3'd5;
  localparam logic [2:0] ST_LOAD_OVF    = 3'd6;

  // Simultaneous core events resolve by severity.
  function automatic logic [2:0] event_code(
    input logic err,
    input logic exc,
    input logic pop,
    input logic fin
  );
    logic [2:0] code;
    code = ST_NONE;
    priority case (1'b1)
      err:     code = ST_INSTR_ERROR;
      exc:     code = ST_STACK_EXC;
      pop:     code = ST_EMPTY_POP;
      fin:     code = ST_FINISH;
      default: code = ST_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/wasm_sat_counter.sv
// Saturating up-counter used for RUN cycle
// accounting; holds at all-ones.
module wasm_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !sat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wasm_run_ctrl.sv
// Run controller: loads the image into BRAM,
// sequences core reset/run and latches status.
module wasm_run_ctrl
  import wasm_run_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_timeout,
  output logic              o_core_rst_n,
  input  logic              i_instr_finish,
  input  logic              i_instr_error,
  input  logic              i_stack_exceed,
  input  logic              i_stack_empty_pop,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_status,
  output logic [CNT_W-1:0]  o_cycle_count
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RST_LAST =
    RC_W'(RST_CYCLES - 1);

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] base;
  logic              full;
  logic [RC_W-1:0]   rst_cnt;
  logic              accept;
  logic              clr;
  logic              sat;
  logic              tmo;
  logic [2:0]        ev;

  assign accept = i_load_valid & o_load_ready;
  assign ev = event_code(i_instr_error, i_stack_exceed,
                         i_stack_empty_pop, i_instr_finish);
  assign tmo = (i_timeout != '0) && !sat &&
               ((o_cycle_count + CNT_W'(1)) == i_timeout);
  assign clr = (state == S_CORE_RST) ||
               (accept && state != S_LOAD);
  // A fresh image always starts at address 0.
  assign base = (state == S_LOAD) ? addr_cnt : '0;

  wasm_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clr),
    .en    (state == S_RUN),
    .count (o_cycle_count),
    .sat   (sat)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) nxt = i_load_last ? S_IDLE : S_LOAD;
        else if (i_start) nxt = S_CORE_RST;
      end
      S_LOAD: begin
        if (accept) begin
          if (full) nxt = S_DONE;
          else if (i_load_last) nxt = S_IDLE;
        end
      end
      S_CORE_RST: if (rst_cnt == RST_LAST) nxt = S_RUN;
      S_RUN: if (ev != ST_NONE || tmo) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_cnt     <= '0;
      full         <= 1'b0;
      rst_cnt      <= '0;
      o_load_ready <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_core_rst_n <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_status     <= ST_NONE;
    end else begin
      state        <= nxt;
      o_mem_we     <= 1'b0;
      o_load_ready <= nxt inside {S_IDLE, S_LOAD, S_DONE};
      o_busy       <= nxt inside {S_LOAD, S_CORE_RST, S_RUN};
      o_done       <= (nxt == S_DONE);
      o_core_rst_n <= (nxt == S_RUN);
      rst_cnt      <= (state == S_CORE_RST) ?
                      rst_cnt + RC_W'(1) : '0;
      if (accept) begin
        if (state == S_LOAD && full) begin
          o_status <= ST_LOAD_OVF;
          addr_cnt <= '0;
          full     <= 1'b0;
        end else begin
          o_mem_we    <= 1'b1;
          o_mem_addr  <= base;
          o_mem_wdata <= i_load_data;
          if (state != S_LOAD) o_status <= ST_NONE;
          if (i_load_last) begin
            addr_cnt <= '0;
            full     <= 1'b0;
          end else begin
            addr_cnt <= base + ADDR_W'(1);
            full     <= &base;
          end
        end
      end
      if (state == S_CORE_RST) o_status <= ST_NONE;
      if (state == S_RUN) begin
        if (ev != ST_NONE) o_status <= ev;
        else if (tmo) o_status <= ST_TIMEOUT;
      end
    end
  end

endmodule
